// File: rtl/freq_div_pkg.sv
// -----------------------------------------------------------------------------
// freq_div_pkg
// Shared definitions for the programmable frequency divider:
//   - mode field width and mode encodings
//   - helper that tells whether a requested mode is loadable
// -----------------------------------------------------------------------------
package freq_div_pkg;

  localparam int MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_TOGGLE = 2'd0; // out inverts each period, 2N period
  localparam logic [MODE_W-1:0] MODE_PULSE  = 2'd1; // out follows tick
  localparam logic [MODE_W-1:0] MODE_DUTY   = 2'd2; // out high for the first ceil(N/2) counts
  localparam logic [MODE_W-1:0] MODE_RSVD   = 2'd3; // reserved, never loaded

  function automatic logic mode_is_valid(input logic [MODE_W-1:0] mode);
    return mode != MODE_RSVD;
  endfunction

endpackage

// File: rtl/freq_div_core.sv
// -----------------------------------------------------------------------------
// freq_div_core
// Period counter, boundary detect and mode-dependent output decode for the
// programmable divider. The active divisor/mode are owned by the parent; this
// block only counts 1..act_div and shapes out/tick from that count.
//
// Ports
//   clk        in   system clock, posedge
//   rst        in   asynchronous active-high reset
//   en         in   count enable; low freezes cnt and out, tick forced 0
//   restart    in   parent is installing a new divisor/mode on this edge
//   act_div    in   divisor currently in force (1..2^CNT_W-1)
//   act_mode   in   mode currently in force
//   next_mode  in   mode that takes effect when restart is high
//   boundary   out  combinational: this edge ends the current period
//   out        out  divided output, registered
//   tick       out  one-cycle pulse after each period boundary, registered
// -----------------------------------------------------------------------------
module freq_div_core
  import freq_div_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              restart,
  input  logic [CNT_W-1:0]  act_div,
  input  logic [MODE_W-1:0] act_mode,
  input  logic [MODE_W-1:0] next_mode,
  output logic              boundary,
  output logic              out,
  output logic              tick
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W:0]   half;     // ceil(act_div/2), one bit wider so N=max cannot wrap
  logic             duty_hi;

  assign boundary = en && (cnt == act_div);
  assign cnt_nxt  = boundary ? CNT_W'(1) : cnt + CNT_W'(1);
  assign half     = ({1'b0, act_div} + (CNT_W+1)'(1)) >> 1;
  // DUTY output is decoded from the count the register will hold next, so out
  // and cnt stay aligned in the same cycle.
  assign duty_hi  = ({1'b0, cnt_nxt} <= half);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= CNT_W'(1);
      out  <= 1'b0;
      tick <= 1'b0;
    end else begin
      tick <= boundary;
      if (restart) begin
        // A fresh period starts at count 1; only DUTY is high on its first cycle.
        cnt <= CNT_W'(1);
        out <= (next_mode == MODE_DUTY);
      end else if (en) begin
        cnt <= cnt_nxt;
        case (act_mode)
          MODE_TOGGLE: if (boundary) out <= ~out;
          MODE_PULSE:  out <= boundary;
          MODE_DUTY:   out <= duty_hi;
          default:     out <= out;
        endcase
      end
    end
  end

endmodule

// File: rtl/freq_div_prog.sv
// -----------------------------------------------------------------------------
// freq_div_prog
// Runtime-programmable divided-clock / clock-enable generator. A load request
// is validated, parked in shadow registers and installed only at a period
// boundary, so a divisor or mode change never cuts a period short. While the
// counter is disabled and nothing is waiting, a load is installed at once.
//
// Ports
//   clk       in   system clock, posedge
//   rst       in   asynchronous active-high reset
//   en        in   count enable
//   div_val   in   requested divisor, sampled when div_load=1
//   mode_val  in   requested mode, sampled with div_val
//   div_load  in   single-cycle load request
//   load_err  out  one-cycle pulse: request rejected (divisor 0 or reserved mode)
//   pending   out  accepted request waiting for the next period boundary
//   out       out  divided output
//   tick      out  one-cycle pulse at the end of every period
// -----------------------------------------------------------------------------
module freq_div_prog
  import freq_div_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int DEF_DIV  = 7,
  parameter int DEF_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [CNT_W-1:0]  div_val,
  input  logic [MODE_W-1:0] mode_val,
  input  logic              div_load,
  output logic              load_err,
  output logic              pending,
  output logic              out,
  output logic              tick
);

  logic [CNT_W-1:0]  act_div;
  logic [MODE_W-1:0] act_mode;
  logic [CNT_W-1:0]  shadow_div;
  logic [MODE_W-1:0] shadow_mode;

  logic              load_ok;
  logic              accept;
  logic              direct;
  logic              apply_b;
  logic              restart;
  logic              boundary;
  logic [CNT_W-1:0]  next_div;
  logic [MODE_W-1:0] next_mode;

  assign load_ok = (div_val != '0) && mode_is_valid(mode_val);
  assign accept  = div_load && load_ok;
  // Idle counter with nothing queued: no boundary will ever come, install now.
  assign direct  = accept && !en && !pending;
  assign apply_b = boundary && pending;
  assign restart = direct || apply_b;

  // NOTE: every signal driven from always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    next_div  = shadow_div;
    next_mode = shadow_mode;
    if (direct) begin
      next_div  = div_val;
      next_mode = mode_val;
    end
  end

  // NOTE: the shadow registers are ordinary flops with a reset value, so a
  // reset mid-operation discards any queued load along with the pending flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_div     <= CNT_W'(DEF_DIV);
      act_mode    <= MODE_W'(DEF_MODE);
      shadow_div  <= CNT_W'(DEF_DIV);
      shadow_mode <= MODE_W'(DEF_MODE);
      pending     <= 1'b0;
      load_err    <= 1'b0;
    end else begin
      load_err <= div_load && !load_ok;
      // Install reads the old shadow before a same-edge load overwrites it.
      if (restart) begin
        act_div  <= next_div;
        act_mode <= next_mode;
      end
      if (accept) begin
        shadow_div  <= div_val;
        shadow_mode <= mode_val;
      end
      // A new accepted load always queues (unless installed directly); an
      // install with no new load empties the queue.
      if (accept && !direct) pending <= 1'b1;
      else if (apply_b)      pending <= 1'b0;
    end
  end

  freq_div_core #(
    .CNT_W (CNT_W)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .restart   (restart),
    .act_div   (act_div),
    .act_mode  (act_mode),
    .next_mode (next_mode),
    .boundary  (boundary),
    .out       (out),
    .tick      (tick)
  );

endmodule

// File: tb/tb_freq_div_prog.sv
// -----------------------------------------------------------------------------
// tb_freq_div_prog
// Self-checking bench for freq_div_prog. A behavioural model tracks the
// position inside the current period, the installed divisor/mode and the
// queued request; every cycle the DUT outputs are compared with it.
// -----------------------------------------------------------------------------
module tb_freq_div_prog;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [CNT_W-1:0] div_val;
  logic [1:0]       mode_val;
  logic             div_load;
  logic             load_err;
  logic             pending;
  logic             out;
  logic             tick;

  int n_chk  = 0;
  int n_fail = 0;

  // Model state: position within the period (0-based), installed settings,
  // queued request and expected outputs.
  int m_pos, m_div, m_mode, m_sh_div, m_sh_mode;
  bit m_pend, m_lvl, m_out, m_tick, m_err;

  freq_div_prog #(.CNT_W(CNT_W), .DEF_DIV(7), .DEF_MODE(0)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .div_val  (div_val),
    .mode_val (mode_val),
    .div_load (div_load),
    .load_err (load_err),
    .pending  (pending),
    .out      (out),
    .tick     (tick)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_pos = 0; m_div = 7; m_mode = 0; m_sh_div = 7; m_sh_mode = 0;
    m_pend = 0; m_lvl = 0; m_out = 0; m_tick = 0; m_err = 0;
  endtask

  // Output of a running period, from the period position and mode rules.
  function automatic bit mode_out(int mode, int pos, int n, bit lvl, bit tk);
    case (mode)
      0:       return lvl;
      1:       return tk;
      default: return (2 * pos < n);
    endcase
  endfunction

  task automatic model_edge(bit e, bit l, int dv, int mv);
    bit last, valid, acc, fresh;
    last  = e && (m_pos == m_div - 1);
    valid = (dv != 0) && (mv != 3);
    acc   = l && valid;
    fresh = 0;
    m_err  = l && !valid;
    m_tick = last;
    if (acc && !e && !m_pend) begin
      m_div = dv; m_mode = mv; m_pos = 0; fresh = 1;
    end else if (e) begin
      if (last) begin
        m_pos = 0;
        if (m_pend) begin
          m_div = m_sh_div; m_mode = m_sh_mode; m_pend = 0; fresh = 1;
        end else if (m_mode == 0) begin
          m_lvl = !m_lvl;
        end
      end else begin
        m_pos++;
      end
    end
    if (fresh) begin
      m_lvl = 0;
      m_out = (m_mode == 2);
    end else if (e) begin
      m_out = mode_out(m_mode, m_pos, m_div, m_lvl, m_tick);
    end
    if (acc) begin
      m_sh_div = dv; m_sh_mode = mv;
      if (!(acc && !e && !fresh && 0) && !(fresh && !e)) m_pend = 1;
    end
  endtask

  // Drive one cycle from a negedge, update the model on the posedge and
  // return at the following negedge with outputs settled.
  task automatic step(bit e, bit l, int dv, int mv);
    en = e; div_load = l; div_val = CNT_W'(dv); mode_val = 2'(mv);
    @(posedge clk);
    model_edge(e, l, dv, mv);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; div_load = 1'b0; div_val = '0; mode_val = '0;
    model_reset();
    #3;
    n_chk++;
    if ({out, tick, pending, load_err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_state: got out/tick/pend/err=%b required 0000",
               {out, tick, pending, load_err});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_default_toggle();
    int toggles = 0;
    bit prev = 0;
    for (int i = 0; i < 42; i++) begin
      step(1, 0, 0, 0);
      n_chk++;
      if ({out, tick, pending, load_err} !== {m_out, m_tick, m_pend, m_err}) begin
        n_fail++;
        $display("FAIL default_toggle cyc %0d: got %b required %b", i,
                 {out, tick, pending, load_err}, {m_out, m_tick, m_pend, m_err});
      end
      if (out != prev) toggles++;
      prev = out;
    end
    // 42 cycles of divide-by-7 toggling: out changes on cycles 7,14,...,42.
    n_chk++;
    if (toggles !== 6) begin
      n_fail++;
      $display("FAIL default_toggle_count: got %0d required 6", toggles);
    end
  endtask

  task automatic test_duty_load();
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 4, 2);
    n_chk++;
    if (pending !== 1'b1 || m_pend !== 1'b1) begin
      n_fail++;
      $display("FAIL duty_pending: got %b required 1", pending);
    end
    for (int i = 0; i < 24; i++) begin
      step(1, 0, 0, 0);
      n_chk++;
      if ({out, tick, pending, load_err} !== {m_out, m_tick, m_pend, m_err}) begin
        n_fail++;
        $display("FAIL duty4 cyc %0d: got %b required %b", i,
                 {out, tick, pending, load_err}, {m_out, m_tick, m_pend, m_err});
      end
    end
  endtask

  task automatic test_odd_and_n1();
    int cfg_div[2]  = '{5, 1};
    int cfg_mode[2] = '{2, 1};
    int highs;
    for (int c = 0; c < 2; c++) begin
      step(1, 1, cfg_div[c], cfg_mode[c]);
      for (int i = 0; i < 14 && m_pend; i++) step(1, 0, 0, 0);
      highs = 0;
      for (int i = 0; i < 20; i++) begin
        step(1, 0, 0, 0);
        if (out) highs++;
        n_chk++;
        if ({out, tick, pending, load_err} !== {m_out, m_tick, m_pend, m_err}) begin
          n_fail++;
          $display("FAIL odd_n1 cfg %0d cyc %0d: got %b required %b", c, i,
                   {out, tick, pending, load_err}, {m_out, m_tick, m_pend, m_err});
        end
      end
      // N=5 duty: 3 of every 5 cycles high -> 12 of 20; N=1 pulse: all 20.
      n_chk++;
      if (highs !== (c == 0 ? 12 : 20)) begin
        n_fail++;
        $display("FAIL odd_n1_highs cfg %0d: got %0d required %0d", c, highs,
                 (c == 0 ? 12 : 20));
      end
    end
  endtask

  task automatic test_load_err();
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    n_chk++;
    if (load_err !== 1'b1 || pending !== 1'b0) begin
      n_fail++;
      $display("FAIL err_div0: got err=%b pend=%b required err=1 pend=0", load_err, pending);
    end
    step(1, 1, 6, 3);
    n_chk++;
    if (load_err !== 1'b1 || pending !== 1'b0) begin
      n_fail++;
      $display("FAIL err_mode3: got err=%b pend=%b required err=1 pend=0", load_err, pending);
    end
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 0, 0);
      n_chk++;
      if ({out, tick, pending, load_err} !== {m_out, m_tick, m_pend, m_err}) begin
        n_fail++;
        $display("FAIL err_after cyc %0d: got %b required %b", i,
                 {out, tick, pending, load_err}, {m_out, m_tick, m_pend, m_err});
      end
    end
  endtask

  task automatic test_back_to_back();
    int budget;
    step(1, 1, 3, 0);
    step(1, 1, 9, 0);
    budget = 0;
    while (m_pend && budget < 20) begin step(1, 0, 0, 0); budget++; end
    n_chk++;
    if (m_div !== 9 || pending !== 1'b0) begin
      n_fail++;
      $display("FAIL overwrite: model div %0d pend %b required div 9 pend 0", m_div, pending);
    end
    // Walk to the last cycle of a period, then load on the boundary edge.
    budget = 0;
    while (m_pos != m_div - 1 && budget < 20) begin step(1, 0, 0, 0); budget++; end
    n_chk++;
    if (budget >= 20) begin
      n_fail++;
      $display("FAIL boundary_search: got budget %0d required < 20", budget);
    end
    step(1, 1, 2, 1);
    n_chk++;
    if (pending !== 1'b1 || tick !== 1'b1) begin
      n_fail++;
      $display("FAIL load_on_boundary: got pend=%b tick=%b required 1 1", pending, tick);
    end
    for (int i = 0; i < 24; i++) begin
      step(1, 0, 0, 0);
      n_chk++;
      if ({out, tick, pending, load_err} !== {m_out, m_tick, m_pend, m_err}) begin
        n_fail++;
        $display("FAIL b2b cyc %0d: got %b required %b", i,
                 {out, tick, pending, load_err}, {m_out, m_tick, m_pend, m_err});
      end
    end
  endtask

  task automatic test_enable_hold();
    step(1, 1, 8, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0);
      n_chk++;
      if ({out, tick, pending, load_err} !== {m_out, 1'b0, m_pend, m_err} || m_tick) begin
        n_fail++;
        $display("FAIL en_hold cyc %0d: got %b required %b", i,
                 {out, tick, pending, load_err}, {m_out, 1'b0, m_pend, m_err});
      end
    end
    for (int i = 0; i < 30 && m_pend; i++) step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 3, 2);
    n_chk++;
    if (pending !== 1'b0 || out !== 1'b1) begin
      n_fail++;
      $display("FAIL direct_load: got pend=%b out=%b required pend=0 out=1", pending, out);
    end
    for (int i = 0; i < 12; i++) begin
      step(1, 0, 0, 0);
      n_chk++;
      if ({out, tick, pending, load_err} !== {m_out, m_tick, m_pend, m_err}) begin
        n_fail++;
        $display("FAIL direct_run cyc %0d: got %b required %b", i,
                 {out, tick, pending, load_err}, {m_out, m_tick, m_pend, m_err});
      end
    end
  endtask

  task automatic test_random();
    bit e, l;
    int dv, mv;
    for (int i = 0; i < 1500; i++) begin
      e  = ($urandom_range(0, 9) < 8);
      l  = ($urandom_range(0, 9) == 0);
      dv = $urandom_range(0, 12);
      mv = $urandom_range(0, 3);
      step(e, l, dv, mv);
      n_chk++;
      if ({out, tick, pending, load_err} !== {m_out, m_tick, m_pend, m_err}) begin
        n_fail++;
        $display("FAIL random cyc %0d: got %b required %b", i,
                 {out, tick, pending, load_err}, {m_out, m_tick, m_pend, m_err});
      end
    end
  endtask

  task automatic test_reset_mid();
    step(1, 1, 3, 1);
    step(1, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    n_chk++;
    if ({out, tick, pending, load_err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_mid: got %b required 0000", {out, tick, pending, load_err});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 0, 0);
      n_chk++;
      if ({out, tick, pending, load_err} !== {m_out, m_tick, m_pend, m_err}) begin
        n_fail++;
        $display("FAIL after_reset cyc %0d: got %b required %b", i,
                 {out, tick, pending, load_err}, {m_out, m_tick, m_pend, m_err});
      end
    end
  endtask

  initial begin
    test_reset();
    test_default_toggle();
    test_duty_load();
    test_odd_and_n1();
    test_load_err();
    test_back_to_back();
    test_enable_hold();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
